// File: rtl/lcd_timing_ctrl.sv
// LCD raster sequencer: walks H/V sync, back porch, active and front porch phases on each
// pixel strobe and produces registered panel strobes plus pixel FIFO fetch requests.
module lcd_timing_ctrl #(
    parameter int unsigned HW = 10,
    parameter int unsigned VW = 10
) (
    input  logic          HCLK,
    input  logic          rst,
    input  logic          en,
    input  logic          pix_tick,
    input  logic [HW-1:0] hsw,
    input  logic [HW-1:0] hbp,
    input  logic [HW-1:0] ppl,
    input  logic [HW-1:0] hfp,
    input  logic [VW-1:0] vsw,
    input  logic [VW-1:0] vbp,
    input  logic [VW-1:0] lpp,
    input  logic [VW-1:0] vfp,
    output logic          lcd_lp,
    output logic          lcd_fp,
    output logic          lcd_enab,
    output logic          pix_req,
    output logic          line_done,
    output logic          frame_done,
    output logic          busy
);

    typedef enum logic {StIdle, StRun} top_e;
    typedef enum logic [1:0] {HSync, HBp, HAct, HFp} h_e;
    typedef enum logic [1:0] {VSync, VBp, VAct, VFp} v_e;

    top_e top_q, top_d;
    h_e h_q, h_d;
    v_e v_q, v_d;
    logic [HW-1:0] hcnt_q, hcnt_d, h_lim;
    logic [VW-1:0] vcnt_q, vcnt_d, v_lim;
    logic [HW-1:0] hsw_q, hbp_q, ppl_q, hfp_q, hsw_d, hbp_d, ppl_d, hfp_d;
    logic [VW-1:0] vsw_q, vbp_q, lpp_q, vfp_q, vsw_d, vbp_d, lpp_d, vfp_d;
    logic lp_q, fp_q, enab_q, req_q, ldone_q, fdone_q, busy_q;
    logic lp_d, fp_d, enab_d, req_d, ldone_d, fdone_d, busy_d;
    logic latch, line_end, frame_end;

    always_comb begin
        top_d     = top_q;
        h_d       = h_q;
        v_d       = v_q;
        hcnt_d    = hcnt_q;
        vcnt_d    = vcnt_q;
        latch     = 1'b0;
        line_end  = 1'b0;
        frame_end = 1'b0;
        h_lim     = hsw_q;
        v_lim     = vsw_q;

        unique case (h_q)
            HSync: h_lim = hsw_q;
            HBp:   h_lim = hbp_q;
            HAct:  h_lim = ppl_q;
            HFp:   h_lim = hfp_q;
        endcase
        unique case (v_q)
            VSync: v_lim = vsw_q;
            VBp:   v_lim = vbp_q;
            VAct:  v_lim = lpp_q;
            VFp:   v_lim = vfp_q;
        endcase

        if (pix_tick) begin
            unique case (top_q)
                StIdle: begin
                    if (en) begin
                        top_d  = StRun;
                        latch  = 1'b1;
                        h_d    = HSync;
                        v_d    = VSync;
                        hcnt_d = '0;
                        vcnt_d = '0;
                    end
                end
                StRun: begin
                    if (hcnt_q == h_lim) begin
                        hcnt_d = '0;
                        unique case (h_q)
                            HSync: h_d = HBp;
                            HBp:   h_d = HAct;
                            HAct:  h_d = HFp;
                            HFp:   h_d = HSync;
                        endcase
                        if (h_q == HFp) begin
                            line_end = 1'b1;
                            if (vcnt_q == v_lim) begin
                                vcnt_d = '0;
                                unique case (v_q)
                                    VSync: v_d = VBp;
                                    VBp:   v_d = VAct;
                                    VAct:  v_d = VFp;
                                    VFp:   v_d = VSync;
                                endcase
                                frame_end = (v_q == VFp);
                            end else begin
                                vcnt_d = vcnt_q + VW'(1);
                            end
                        end
                    end else begin
                        hcnt_d = hcnt_q + HW'(1);
                    end
                    // Frame boundary: either roll straight into the next frame or stop.
                    if (frame_end) begin
                        if (en) begin
                            latch = 1'b1;
                        end else begin
                            top_d = StIdle;
                        end
                    end
                end
            endcase
        end

        hsw_d = latch ? hsw : hsw_q;
        hbp_d = latch ? hbp : hbp_q;
        ppl_d = latch ? ppl : ppl_q;
        hfp_d = latch ? hfp : hfp_q;
        vsw_d = latch ? vsw : vsw_q;
        vbp_d = latch ? vbp : vbp_q;
        lpp_d = latch ? lpp : lpp_q;
        vfp_d = latch ? vfp : vfp_q;

        busy_d  = (top_d == StRun);
        lp_d    = busy_d && (h_d == HSync);
        fp_d    = busy_d && (v_d == VSync);
        enab_d  = busy_d && (h_d == HAct) && (v_d == VAct);
        req_d   = pix_tick && enab_d;
        ldone_d = line_end;
        fdone_d = frame_end;
    end

    always_ff @(posedge HCLK or posedge rst) begin
        if (rst) begin
            top_q   <= StIdle;
            h_q     <= HSync;
            v_q     <= VSync;
            hcnt_q  <= '0;
            vcnt_q  <= '0;
            hsw_q   <= '0;
            hbp_q   <= '0;
            ppl_q   <= '0;
            hfp_q   <= '0;
            vsw_q   <= '0;
            vbp_q   <= '0;
            lpp_q   <= '0;
            vfp_q   <= '0;
            lp_q    <= 1'b0;
            fp_q    <= 1'b0;
            enab_q  <= 1'b0;
            req_q   <= 1'b0;
            ldone_q <= 1'b0;
            fdone_q <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            top_q   <= top_d;
            h_q     <= h_d;
            v_q     <= v_d;
            hcnt_q  <= hcnt_d;
            vcnt_q  <= vcnt_d;
            hsw_q   <= hsw_d;
            hbp_q   <= hbp_d;
            ppl_q   <= ppl_d;
            hfp_q   <= hfp_d;
            vsw_q   <= vsw_d;
            vbp_q   <= vbp_d;
            lpp_q   <= lpp_d;
            vfp_q   <= vfp_d;
            lp_q    <= lp_d;
            fp_q    <= fp_d;
            enab_q  <= enab_d;
            req_q   <= req_d;
            ldone_q <= ldone_d;
            fdone_q <= fdone_d;
            busy_q  <= busy_d;
        end
    end

    assign lcd_lp     = lp_q;
    assign lcd_fp     = fp_q;
    assign lcd_enab   = enab_q;
    assign pix_req    = req_q;
    assign line_done  = ldone_q;
    assign frame_done = fdone_q;
    assign busy       = busy_q;

endmodule

// File: tb/tb_lcd_timing_ctrl.sv
// Bench for lcd_timing_ctrl: a frame-position model checked every cycle, plus directed
// scenarios with hand-computed counts and periods.
module tb_lcd_timing_ctrl;

    logic       HCLK = 1'b0;
    logic       rst = 1'b1;
    logic       en = 1'b0;
    logic       pix_tick = 1'b0;
    logic [9:0] hsw = '0, hbp = '0, ppl = '0, hfp = '0;
    logic [9:0] vsw = '0, vbp = '0, lpp = '0, vfp = '0;
    logic lcd_lp, lcd_fp, lcd_enab, pix_req, line_done, frame_done, busy;

    lcd_timing_ctrl #(.HW(10), .VW(10)) dut (
        .HCLK(HCLK), .rst(rst), .en(en), .pix_tick(pix_tick),
        .hsw(hsw), .hbp(hbp), .ppl(ppl), .hfp(hfp),
        .vsw(vsw), .vbp(vbp), .lpp(lpp), .vfp(vfp),
        .lcd_lp(lcd_lp), .lcd_fp(lcd_fp), .lcd_enab(lcd_enab), .pix_req(pix_req),
        .line_done(line_done), .frame_done(frame_done), .busy(busy)
    );

    always #5 HCLK = ~HCLK;

    int n_vec = 0;
    int n_bad = 0;

    task automatic check(input string nm, input int got, input int exp);
        n_vec++;
        if (got != exp) begin
            n_bad++;
            if (n_bad <= 40) $display("FAIL %s: got %0d, expected %0d at %0t", nm, got, exp, $time);
        end
    endtask

    // Model: a frame is a flat sequence of line_len*lines tick positions; outputs follow
    // from where the position falls within its line and within the frame.
    int  cf[8];
    bit  m_run = 0;
    int  m_p = 0;
    bit  e_lp, e_fp, e_en, e_pr, e_ld, e_fd;
    int  cnt_fd = 0, cnt_pr = 0, cnt_ld = 0, cnt_lp = 0, cnt_fp = 0;

    task automatic load_cfg();
        cf[0] = int'(hsw); cf[1] = int'(hbp); cf[2] = int'(ppl); cf[3] = int'(hfp);
        cf[4] = int'(vsw); cf[5] = int'(vbp); cf[6] = int'(lpp); cf[7] = int'(vfp);
    endtask

    always @(posedge HCLK) begin
        int ll, fl, x, ln, hs, vs;
        e_ld = 0;
        e_fd = 0;
        if (rst) begin
            m_run = 0;
            m_p   = 0;
            foreach (cf[i]) cf[i] = 0;
        end else if (pix_tick) begin
            if (!m_run) begin
                if (en) begin
                    m_run = 1;
                    m_p   = 0;
                    load_cfg();
                end
            end else begin
                ll = cf[0] + cf[1] + cf[2] + cf[3] + 4;
                fl = ll * (cf[4] + cf[5] + cf[6] + cf[7] + 4);
                e_ld = (m_p % ll == ll - 1);
                if (m_p == fl - 1) begin
                    e_fd = 1;
                    m_p  = 0;
                    if (en) load_cfg();
                    else m_run = 0;
                end else begin
                    m_p++;
                end
            end
        end
        ll = cf[0] + cf[1] + cf[2] + cf[3] + 4;
        x  = m_p % ll;
        ln = m_p / ll;
        hs = cf[0] + cf[1] + 2;
        vs = cf[4] + cf[5] + 2;
        e_lp = m_run && (x <= cf[0]);
        e_fp = m_run && (ln <= cf[4]);
        e_en = m_run && (x >= hs) && (x <= hs + cf[2]) && (ln >= vs) && (ln <= vs + cf[6]);
        e_pr = !rst && pix_tick && e_en;
        #1;
        check("outputs{lp,fp,enab,req,ldone,fdone,busy}",
              int'({lcd_lp, lcd_fp, lcd_enab, pix_req, line_done, frame_done, busy}),
              int'({e_lp, e_fp, e_en, e_pr, e_ld, e_fd, m_run}));
        cnt_fd += int'(frame_done);
        cnt_pr += int'(pix_req);
        cnt_ld += int'(line_done);
        cnt_lp += int'(lcd_lp);
        cnt_fp += int'(lcd_fp);
    end

    bit tick_cont = 0;
    int ph = 0;

    task automatic step();
        @(negedge HCLK);
        if (tick_cont) begin
            pix_tick = 1'b1;
        end else begin
            pix_tick = (ph == 0);
            ph = (ph + 1) % 4;
        end
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic wait_fd(input string nm, output int n);
        n = -1;
        for (int i = 1; i <= 400; i++) begin
            step();
            if (frame_done) begin
                n = i;
                break;
            end
        end
        if (n < 0) check({nm, " frame_done timeout"}, 0, 1);
    endtask

    initial begin
        int n, s_fd, s_pr, s_ld, s_lp, s_fp;
        hsw = 10'd1; hbp = 10'd1; ppl = 10'd3; hfp = 10'd0;
        vsw = 10'd0; vbp = 10'd0; lpp = 10'd1; vfp = 10'd0;
        en = 1'b1;
        run(4);
        check("reset outputs", int'({lcd_lp, lcd_fp, lcd_enab, pix_req, line_done,
              frame_done, busy}), 0);
        rst = 1'b0;

        // Pixel strobe every 4 HCLK
        wait_fd("t1 sync", n);
        run(2);
        s_fd = cnt_fd; s_pr = cnt_pr; s_ld = cnt_ld; s_lp = cnt_lp;
        run(180);
        check("t1 frame_done per 180", cnt_fd - s_fd, 1);
        check("t1 pix_req per frame", cnt_pr - s_pr, 8);
        check("t1 line_done per frame", cnt_ld - s_ld, 5);
        check("t1 lcd_lp cycles per frame", cnt_lp - s_lp, 40);

        // Strobe tied high
        tick_cont = 1;
        wait_fd("t2 sync", n);
        wait_fd("t2 period", n);
        check("t2 frame period", n, 45);
        run(2);
        s_fd = cnt_fd; s_ld = cnt_ld; s_fp = cnt_fp;
        run(45);
        check("t2 frame_done per 45", cnt_fd - s_fd, 1);
        check("t2 line_done per 45", cnt_ld - s_ld, 5);
        check("t2 lcd_fp cycles per 45", cnt_fp - s_fp, 9);

        // Mid-frame ppl change
        wait_fd("t3 sync", n);
        s_pr = cnt_pr;
        run(5);
        ppl = 10'd7;
        wait_fd("t3 old frame", n);
        check("t3 old frame pix_req", cnt_pr - s_pr, 8);
        check("t3 old frame period", n + 5, 45);
        s_pr = cnt_pr;
        wait_fd("t3 new frame", n);
        check("t3 new frame pix_req", cnt_pr - s_pr, 16);
        check("t3 new frame period", n, 65);
        ppl = 10'd3;

        // en dropped mid-frame
        wait_fd("t4 sync", n);
        run(9);
        en = 1'b0;
        wait_fd("t4 end", n);
        check("t4 remaining ticks", n, 36);
        check("t4 busy at frame_done", int'(busy), 0);
        s_pr = cnt_pr;
        run(50);
        check("t4 pix_req while idle", cnt_pr - s_pr, 0);
        check("t4 idle outputs", int'({lcd_lp, lcd_fp, lcd_enab, busy}), 0);
        en = 1'b1;

        // Async reset during H_ACT of line 3
        wait_fd("t5 sync", n);
        run(22);
        check("t5 enab before reset", int'(lcd_enab), 1);
        #2 rst = 1'b1;
        #1 check("t5 async reset outputs", int'({lcd_lp, lcd_fp, lcd_enab, busy}), 0);
        run(2);
        rst = 1'b0;
        step();
        check("t5 restart lp/fp/busy", int'({lcd_lp, lcd_fp, lcd_enab, busy}), 4'b1101);

        // All fields zero
        hsw = '0; hbp = '0; ppl = '0; hfp = '0; vsw = '0; vbp = '0; lpp = '0; vfp = '0;
        wait_fd("t6 sync", n);
        s_pr = cnt_pr;
        wait_fd("t6 period", n);
        check("t6 frame period", n, 16);
        check("t6 pix_req per frame", cnt_pr - s_pr, 1);
        check("t6 line_done with frame_done", int'(line_done), 1);

        run(3);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
